// File: rtl/mips_isa_pkg.sv
// MIPS ISA subset shared by the loader-side encoder and the core decoder.
// Mnemonic codes, opcode/funct values and word-packing helpers.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        MN_ADD  = 5'd0,
        MN_SUB  = 5'd1,
        MN_AND  = 5'd2,
        MN_OR   = 5'd3,
        MN_SLT  = 5'd4,
        MN_SRL  = 5'd5,
        MN_XOR  = 5'd6,
        MN_JR   = 5'd7,
        MN_JALR = 5'd8,
        MN_LW   = 5'd9,
        MN_SW   = 5'd10,
        MN_BEQ  = 5'd11,
        MN_BNE  = 5'd12,
        MN_J    = 5'd13,
        MN_JAL  = 5'd14,
        MN_ADDI = 5'd15,
        MN_ANDI = 5'd16,
        MN_ORI  = 5'd17,
        MN_XORI = 5'd18,
        MN_SLTI = 5'd19,
        MN_LUI  = 5'd20
    } mnemonic_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    function automatic logic [31:0] r_word(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sh,
        input logic [5:0] fn
    );
        return {OP_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(
        input logic [5:0]  op,
        input logic [25:0] idx
    );
        return {op, idx};
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: mnemonic, fields and slot PC to a MIPS word.
// Also resolves branch/jump targets and reports encoding errors.
module instr_field_pack
    import mips_isa_pkg::*;
(
    input  logic [4:0]  mn_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [31:0] target_i,
    input  logic [31:0] pc_i,
    output logic [31:0] word_o,
    output logic        err_op_o,
    output logic        err_range_o
);

    logic [31:0] pc4;
    logic [31:0] diff;
    logic [31:0] off;
    logic        misalign;
    logic        br_err;
    logic        j_err;

    assign pc4      = pc_i + 32'd4;
    assign diff     = target_i - pc4;
    assign off      = 32'($signed(diff) >>> 2);
    assign misalign = target_i[1:0] != 2'b00;

    // Offset fits in 16 bits only if bits 31..15 are all sign copies
    assign br_err = (off[31:15] != {17{off[31]}}) | misalign;
    assign j_err  = (target_i[31:28] != pc4[31:28]) | misalign;

    always_comb begin
        word_o      = '0;
        err_op_o    = 1'b0;
        err_range_o = 1'b0;
        case (mn_i)
            MN_ADD:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
            MN_SUB:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
            MN_AND:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_AND);
            MN_OR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_OR);
            MN_SLT:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SLT);
            MN_SRL:  word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SRL);
            MN_XOR:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_XOR);
            MN_JR:   word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_JALR: word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_JALR);
            MN_LW:   word_o = i_word(OP_LW, rs_i, rt_i, imm_i);
            MN_SW:   word_o = i_word(OP_SW, rs_i, rt_i, imm_i);
            MN_BEQ: begin
                word_o      = i_word(OP_BEQ, rs_i, rt_i, off[15:0]);
                err_range_o = br_err;
            end
            MN_BNE: begin
                word_o      = i_word(OP_BNE, rs_i, rt_i, off[15:0]);
                err_range_o = br_err;
            end
            MN_J: begin
                word_o      = j_word(OP_J, target_i[27:2]);
                err_range_o = j_err;
            end
            MN_JAL: begin
                word_o      = j_word(OP_JAL, target_i[27:2]);
                err_range_o = j_err;
            end
            MN_ADDI: word_o = i_word(OP_ADDI, rs_i, rt_i, imm_i);
            MN_ANDI: word_o = i_word(OP_ANDI, rs_i, rt_i, imm_i);
            MN_ORI:  word_o = i_word(OP_ORI, rs_i, rt_i, imm_i);
            MN_XORI: word_o = i_word(OP_XORI, rs_i, rt_i, imm_i);
            MN_SLTI: word_o = i_word(OP_SLTI, rs_i, rt_i, imm_i);
            MN_LUI:  word_o = i_word(OP_LUI, 5'd0, rt_i, imm_i);
            default: err_op_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Loader-side MIPS encoder: accepts symbolic instructions and writes
// encoded words to sequential instruction-memory addresses.
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] TEXT_BASE = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mn,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [31:0]       in_target,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              full,
    output logic              err_op,
    output logic              err_range
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              full_q, full_d;
    logic              err_op_q, err_op_d;
    logic              err_rng_q, err_rng_d;

    logic [ADDR_W-1:0] slot;
    logic [31:0]       slot_pc;
    logic [31:0]       pk_word;
    logic              pk_err_op;
    logic              pk_err_rng;
    logic              fire;
    logic              done;

    assign in_ready = !base_load & !full_q & (!wr_en_q | wr_ready);
    assign fire     = in_valid & in_ready;
    assign done     = wr_en_q & wr_ready;

    // Counter only moves on completion, so an accept that overlaps
    // a completing write lands one slot past the counter.
    assign slot    = wr_en_q ? cnt_q + ADDR_W'(1) : cnt_q;
    assign slot_pc = TEXT_BASE + (32'(slot) << 2);

    instr_field_pack u_pack (
        .mn_i        (in_mn),
        .rs_i        (in_rs),
        .rt_i        (in_rt),
        .rd_i        (in_rd),
        .shamt_i     (in_shamt),
        .imm_i       (in_imm),
        .target_i    (in_target),
        .pc_i        (slot_pc),
        .word_o      (pk_word),
        .err_op_o    (pk_err_op),
        .err_range_o (pk_err_rng)
    );

    always_comb begin
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = wr_en_q;
        full_d    = full_q;
        err_op_d  = err_op_q;
        err_rng_d = err_rng_q;
        if (base_load) begin
            cnt_d     = base_addr;
            wr_en_d   = 1'b0;
            full_d    = 1'b0;
            err_op_d  = 1'b0;
            err_rng_d = 1'b0;
        end else begin
            if (done) begin
                cnt_d   = cnt_q + ADDR_W'(1);
                wr_en_d = 1'b0;
                if (cnt_q == LAST) begin
                    full_d = 1'b1;
                end
            end
            if (fire) begin
                if (pk_err_op) begin
                    err_op_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = slot;
                    wr_data_d = pk_word;
                    if (pk_err_rng) begin
                        err_rng_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            full_q    <= 1'b0;
            err_op_q  <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            full_q    <= full_d;
            err_op_q  <= err_op_d;
            err_rng_q <= err_rng_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign full      = full_q;
    assign err_op    = err_op_q;
    assign err_range = err_rng_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder.
// Expected words are hand-encoded MIPS instructions.
module tb_instr_encoder;
    import mips_isa_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        base_load;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_mn;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [31:0] in_target;
    logic        wr_en;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        full;
    logic        err_op;
    logic        err_range;

    int total = 0;
    int bad   = 0;

    instr_encoder #(
        .ADDR_W    (8),
        .TEXT_BASE (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_load (base_load),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mn     (in_mn),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .in_target (in_target),
        .wr_en     (wr_en),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .full      (full),
        .err_op    (err_op),
        .err_range (err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [4:0] mn, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [4:0] sh, input logic [15:0] imm,
                           input logic [31:0] tgt);
        in_mn     = mn;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_shamt  = sh;
        in_imm    = imm;
        in_target = tgt;
        in_valid  = 1'b1;
    endtask

    // Drive one request, wait (bounded) for acceptance, return #1 after it.
    task automatic issue(input logic [4:0] mn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh, input logic [15:0] imm,
                         input logic [31:0] tgt);
        int n;
        @(negedge clk);
        set_req(mn, rs, rt, rd, sh, imm, tgt);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_base(input logic [7:0] a);
        @(negedge clk);
        base_load = 1'b1;
        base_addr = a;
        #1 chk("base_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 base_load = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        base_load = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_mn     = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_rd     = '0;
        in_shamt  = '0;
        in_imm    = '0;
        in_target = '0;
        wr_ready  = 1'b1;

        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err_op", 32'(err_op), 32'd0);
        chk("rst_err_range", 32'(err_range), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        issue(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0);
        chk("add_wr_en", 32'(wr_en), 32'd1);
        chk("add_addr", 32'(wr_addr), 32'd0);
        chk("add_data", wr_data, 32'h0022_1820);

        issue(MN_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 32'h0);
        chk("lw_addr", 32'(wr_addr), 32'd1);
        chk("lw_data", wr_data, 32'h8FA8_0004);

        issue(MN_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'h0);
        chk("beq_addr", 32'(wr_addr), 32'd2);
        chk("beq_data", wr_data, 32'h1022_FFFD);
        chk("beq_err", 32'(err_range), 32'd0);

        @(posedge clk);
        #1 chk("drain_wr_en", 32'(wr_en), 32'd0);

        do_base(8'd0);
        issue(MN_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0000_0040);
        chk("j_addr", 32'(wr_addr), 32'd0);
        chk("j_data", wr_data, 32'h0800_0010);
        chk("j_err", 32'(err_range), 32'd0);

        do_base(8'd0);
        issue(MN_BEQ, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0004_0000);
        chk("beqovf_data", wr_data, 32'h1000_FFFF);
        chk("beqovf_err", 32'(err_range), 32'd1);
        repeat (2) @(posedge clk);
        #1 chk("beqovf_sticky", 32'(err_range), 32'd1);
        do_base(8'd0);
        chk("base_clr_err", 32'(err_range), 32'd0);

        // Backpressure: first word must hold while the second waits.
        @(negedge clk);
        wr_ready = 1'b0;
        issue(MN_ADD, 5'd2, 5'd3, 5'd1, 5'd0, 16'h0, 32'h0);
        chk("stall_a_addr", 32'(wr_addr), 32'd0);
        chk("stall_a_data", wr_data, 32'h0043_0820);
        @(negedge clk);
        set_req(MN_SUB, 5'd5, 5'd6, 5'd4, 5'd0, 16'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_hold", wr_data, 32'h0043_0820);
            @(negedge clk);
        end
        wr_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("stall_b_addr", 32'(wr_addr), 32'd1);
        chk("stall_b_data", wr_data, 32'h00A6_2022);
        @(posedge clk);
        #1 chk("stall_b_done", 32'(wr_en), 32'd0);

        do_base(8'd252);
        for (int k = 0; k < 4; k++) begin
            issue(MN_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 16'(k), 32'h0);
            chk("fill_addr", 32'(wr_addr), 32'd252 + 32'(k));
            chk("fill_data", wr_data, 32'h3401_0000 | 32'(k));
        end
        @(posedge clk);
        #1;
        chk("full_set", 32'(full), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_wr_en", 32'(wr_en), 32'd0);
        do_base(8'd1);
        chk("full_clr", 32'(full), 32'd0);
        issue(MN_ADDI, 5'd0, 5'd2, 5'd0, 5'd0, 16'h7FFF, 32'h0);
        chk("rebase_addr", 32'(wr_addr), 32'd1);
        chk("rebase_data", wr_data, 32'h2002_7FFF);

        issue(5'd25, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 32'h0);
        chk("illegal_wr_en", 32'(wr_en), 32'd0);
        chk("illegal_err_op", 32'(err_op), 32'd1);

        issue(MN_LUI, 5'd9, 5'd3, 5'd0, 5'd0, 16'h1234, 32'h0);
        chk("lui_addr", 32'(wr_addr), 32'd2);
        chk("lui_data", wr_data, 32'h3C03_1234);

        issue(MN_JR, 5'd31, 5'd5, 5'd5, 5'd3, 16'h0, 32'h0);
        chk("jr_addr", 32'(wr_addr), 32'd3);
        chk("jr_data", wr_data, 32'h03E0_0008);

        @(posedge clk);
        #1 wr_ready = 1'b0;
        issue(MN_SRL, 5'd7, 5'd6, 5'd5, 5'd4, 16'h0, 32'h0);
        chk("srl_addr", 32'(wr_addr), 32'd4);
        chk("srl_data", wr_data, 32'h0006_2902);

        // Asynchronous reset while the write is stalled.
        @(negedge clk);
        chk("prerst_wr_en", 32'(wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_addr", 32'(wr_addr), 32'd0);
        chk("midrst_data", wr_data, 32'd0);
        chk("midrst_err_op", 32'(err_op), 32'd0);
        chk("midrst_full", 32'(full), 32'd0);
        wr_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("postrst_in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
